// File: rtl/mux153_scan.sv
// Scan sequencer for a dual 4-to-1 data selector: steps the select code 0..3,
// samples both group outputs after a settle window and holds the words under valid/ack.
module mux153_scan #(
    parameter int SETTLE = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [1:0] en_mask,
    output logic       sel0,
    output logic       sel1,
    output logic       enb1_n,
    output logic       enb2_n,
    input  logic       g1q,
    input  logic       g2q,
    output logic [3:0] word1,
    output logic [3:0] word2,
    output logic       valid,
    input  logic       ack,
    output logic       busy
);

    generate
        if (SETTLE < 1 || SETTLE > 15) begin : g_bad_settle
            $error("mux153_scan: SETTLE must be in 1..15");
        end
    endgenerate

    typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_SAMPLE, S_HOLD} state_t;

    localparam logic [3:0] CNT_LAST = 4'(SETTLE - 1);

    state_t     state;
    logic [1:0] idx;
    logic [3:0] cnt;
    logic [1:0] mask_r;
    logic [3:0] sh1;
    logic [3:0] sh2;
    logic [3:0] sh1_next;
    logic [3:0] sh2_next;
    logic       launch;

    // A scan may start from IDLE, or straight out of HOLD when ack and start coincide.
    always_comb begin
        launch        = start && ((state == S_IDLE) || (state == S_HOLD && ack));
        sh1_next      = sh1;
        sh2_next      = sh2;
        sh1_next[idx] = g1q & mask_r[0];
        sh2_next[idx] = g2q & mask_r[1];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= S_IDLE;
            idx    <= 2'd0;
            cnt    <= 4'd0;
            mask_r <= 2'd0;
            sh1    <= 4'd0;
            sh2    <= 4'd0;
            word1  <= 4'd0;
            word2  <= 4'd0;
            sel0   <= 1'b0;
            sel1   <= 1'b0;
            enb1_n <= 1'b1;
            enb2_n <= 1'b1;
            valid  <= 1'b0;
            busy   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: state <= S_IDLE;
                S_SETTLE: begin
                    cnt <= cnt + 4'd1;
                    if (cnt == CNT_LAST) state <= S_SAMPLE;
                end
                S_SAMPLE: begin
                    sh1 <= sh1_next;
                    sh2 <= sh2_next;
                    if (idx == 2'd3) begin
                        // Words take the shadow including the bit sampled on this edge.
                        word1        <= sh1_next;
                        word2        <= sh2_next;
                        state        <= S_HOLD;
                        valid        <= 1'b1;
                        busy         <= 1'b0;
                        {sel1, sel0} <= 2'd0;
                        enb1_n       <= 1'b1;
                        enb2_n       <= 1'b1;
                    end else begin
                        idx          <= idx + 2'd1;
                        {sel1, sel0} <= idx + 2'd1;
                        cnt          <= 4'd0;
                        state        <= S_SETTLE;
                    end
                end
                S_HOLD: begin
                    if (ack) begin
                        valid <= 1'b0;
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase

            // Scan launch overrides the per-state updates above.
            if (launch) begin
                state        <= S_SETTLE;
                mask_r       <= en_mask;
                idx          <= 2'd0;
                cnt          <= 4'd0;
                sh1          <= 4'd0;
                sh2          <= 4'd0;
                {sel1, sel0} <= 2'd0;
                enb1_n       <= ~en_mask[0];
                enb2_n       <= ~en_mask[1];
                busy         <= 1'b1;
                valid        <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mux153_scan.sv
// Directed bench for mux153_scan: SETTLE=2 instance for function/handshake,
// SETTLE=15 instance for latency and mid-scan reset.
module tb_mux153_scan;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int failed = 0;

    logic [3:0] g1c, g2c;

    logic       reset, start, ack, g1q, g2q;
    logic [1:0] en_mask;
    logic       sel0, sel1, enb1_n, enb2_n, valid, busy;
    logic [3:0] word1, word2;

    logic       b_reset, b_start, b_ack, b_g1q, b_g2q;
    logic [1:0] b_en_mask;
    logic       b_sel0, b_sel1, b_enb1_n, b_enb2_n, b_valid, b_busy;
    logic [3:0] b_word1, b_word2;

    // Selector models: a disabled group outputs 0.
    assign g1q   = ~enb1_n & g1c[{sel1, sel0}];
    assign g2q   = ~enb2_n & g2c[{sel1, sel0}];
    assign b_g1q = ~b_enb1_n & g1c[{b_sel1, b_sel0}];
    assign b_g2q = ~b_enb2_n & g2c[{b_sel1, b_sel0}];

    mux153_scan #(.SETTLE(2)) dut (
        .clk(clk), .reset(reset), .start(start), .en_mask(en_mask),
        .sel0(sel0), .sel1(sel1), .enb1_n(enb1_n), .enb2_n(enb2_n),
        .g1q(g1q), .g2q(g2q), .word1(word1), .word2(word2),
        .valid(valid), .ack(ack), .busy(busy)
    );

    mux153_scan #(.SETTLE(15)) dut15 (
        .clk(clk), .reset(b_reset), .start(b_start), .en_mask(b_en_mask),
        .sel0(b_sel0), .sel1(b_sel1), .enb1_n(b_enb1_n), .enb2_n(b_enb2_n),
        .g1q(b_g1q), .g2q(b_g2q), .word1(b_word1), .word2(b_word2),
        .valid(b_valid), .ack(b_ack), .busy(b_busy)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Full scan on the SETTLE=15 instance: valid must rise exactly 64 edges after start.
    task automatic b_scan_full(input string tag);
        b_en_mask = 2'b11;
        b_start   = 1'b1;
        tick();
        b_start = 1'b0;
        repeat (63) tick();
        check({tag, "_valid_early"}, b_valid, 0);
        check({tag, "_busy_last"}, b_busy, 1);
        tick();
        check({tag, "_valid_64"}, b_valid, 1);
        check({tag, "_word1"}, b_word1, g1c);
        check({tag, "_word2"}, b_word2, g2c);
    endtask

    initial begin
        g1c = 4'b1010; g2c = 4'b0110;
        reset = 1'b1; start = 1'b1; ack = 1'b0; en_mask = 2'b11;
        b_reset = 1'b1; b_start = 1'b0; b_ack = 1'b0; b_en_mask = 2'b00;
        tick(); tick();
        reset = 1'b0; start = 1'b0; b_reset = 1'b0;

        check("rst_sel", {sel1, sel0}, 0);
        check("rst_enb", {enb2_n, enb1_n}, 2'b11);
        check("rst_words", {word2, word1}, 0);
        check("rst_valid", valid, 0);
        check("rst_busy_start_ignored", busy, 0);

        // Basic scan, both groups enabled.
        en_mask = 2'b11; start = 1'b1;
        tick();
        start = 1'b0;
        for (int j = 0; j < 12; j++) begin
            check($sformatf("basic_sel_c%0d", j), {sel1, sel0}, j / 3);
            check($sformatf("basic_busy_c%0d", j), busy, 1);
            check($sformatf("basic_valid_c%0d", j), valid, 0);
            tick();
        end
        check("basic_valid", valid, 1);
        check("basic_busy_off", busy, 0);
        check("basic_word1", word1, 4'b1010);
        check("basic_word2", word2, 4'b0110);
        check("basic_hold_sel", {sel1, sel0}, 0);
        check("basic_hold_enb", {enb2_n, enb1_n}, 2'b11);

        // Handshake: no ack for 20 cycles, start pulsed during HOLD is ignored.
        for (int i = 0; i < 20; i++) begin
            start = (i == 5);
            tick();
            check($sformatf("hold_valid_%0d", i), valid, 1);
            check($sformatf("hold_busy_%0d", i), busy, 0);
            check($sformatf("hold_word1_%0d", i), word1, 4'b1010);
        end
        start = 1'b0; ack = 1'b1;
        tick();
        ack = 1'b0;
        check("ack_valid_low", valid, 0);
        check("ack_idle_busy", busy, 0);
        check("ack_words_kept", {word2, word1}, {4'b0110, 4'b1010});

        // Masking: group 2 disabled.
        en_mask = 2'b01; start = 1'b1;
        tick();
        start = 1'b0;
        for (int j = 0; j < 12; j++) begin
            check($sformatf("mask_enb2_c%0d", j), enb2_n, 1);
            check($sformatf("mask_enb1_c%0d", j), enb1_n, 0);
            tick();
        end
        check("mask_valid", valid, 1);
        check("mask_word1", word1, 4'b1010);
        check("mask_word2", word2, 4'b0000);

        // Back-to-back: ack and start together in HOLD.
        g1c = 4'b0101; en_mask = 2'b11; ack = 1'b1; start = 1'b1;
        tick();
        ack = 1'b0; start = 1'b0;
        check("b2b_busy_rise", busy, 1);
        check("b2b_valid_fall", valid, 0);
        check("b2b_word1_kept", word1, 4'b1010);
        repeat (11) tick();
        check("b2b_valid_early", valid, 0);
        tick();
        check("b2b_valid", valid, 1);
        check("b2b_word1", word1, 4'b0101);
        check("b2b_word2", word2, 4'b0110);

        // SETTLE=15: full scan, then reset while idx=2, then a fresh scan.
        b_scan_full("s15_first");
        b_ack = 1'b1;
        tick();
        b_ack = 1'b0;
        b_en_mask = 2'b11; b_start = 1'b1;
        tick();
        b_start = 1'b0;
        repeat (40) tick();
        check("abort_idx2", {b_sel1, b_sel0}, 2'd2);
        b_reset = 1'b1;
        tick();
        b_reset = 1'b0;
        check("abort_sel", {b_sel1, b_sel0}, 0);
        check("abort_enb", {b_enb2_n, b_enb1_n}, 2'b11);
        check("abort_busy", b_busy, 0);
        check("abort_valid", b_valid, 0);
        check("abort_words", {b_word2, b_word1}, 0);
        repeat (30) tick();
        check("abort_no_valid", b_valid, 0);
        check("abort_still_idle", b_busy, 0);
        b_scan_full("s15_fresh");

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/mux153_scan.md
# mux153_scan

Sequencer that drives the select and enable inputs of a dual 4-to-1 data selector and reads back its two group outputs. On each `start` it steps the select code through 0..3, waits a programmable settle time per code, and samples G1Q/G2Q into two 4-bit words. The words are then held under a valid/ack handshake. It sits directly upstream of the selector, driving SEL0/SEL1/ENB1_N/ENB2_N, and directly downstream of it, consuming G1Q/G2Q.

## Interface
- `SETTLE`, default 2: clock cycles between a select/enable change and the sample. Legal range 1..15; any other value is an elaboration error.

- `clk`  in  1  single clock, all state changes on rising edge
- `reset`  in  1  reset is synchronous and active-high
- `start`  in  1  request a scan; level-sampled, accepted only as below
- `en_mask`  in  2  bit0 enables group 1, bit1 enables group 2; captured when a scan starts
- `sel0`, `sel1`  out  1 each  to selector SEL0/SEL1
- `enb1_n`, `enb2_n`  out  1 each  to selector ENB1_N/ENB2_N, active low
- `g1q`, `g2q`  in  1 each  from selector G1Q/G2Q
- `word1`, `word2`  out  4 each  assembled words; bit i is the sample taken with select code i
- `valid`  out  1  words available
- `ack`  in  1  consumer has taken the words
- `busy`  out  1  scan in progress

## Operation
- States: IDLE, SETTLE, SAMPLE, HOLD. Internal signals:
  - `idx` (2 bits): current select code.
  - `cnt` (4 bits): settle counter.
  - `mask_r` (2 bits): captured copy of `en_mask`.
  - Shadow registers `sh1` and `sh2` (4 bits each).
- Output mapping:
  - `{sel1,sel0}` = `idx` in SETTLE and SAMPLE. It is 00 in IDLE and HOLD.
  - `enb1_n` = ~`mask_r[0]` and `enb2_n` = ~`mask_r[1]` in SETTLE and SAMPLE. Both are 1 in IDLE and HOLD.
  - `busy` = 1 in SETTLE and SAMPLE.
  - `valid` = 1 in HOLD only.
- IDLE:
  - If `start`=1: `mask_r` ← `en_mask`, `idx` ← 0, `cnt` ← 0, `sh1`/`sh2` ← 0, go to SETTLE.
  - Otherwise stay in IDLE.
- SETTLE:
  - `cnt` increments each edge.
  - When `cnt` = SETTLE-1, go to SAMPLE.
- SAMPLE, one cycle. At the edge:
  - `sh1[idx]` ← `g1q & mask_r[0]` and `sh2[idx]` ← `g2q & mask_r[1]`.
  - If `idx` = 3: `word1`/`word2` ← the completed shadow values, including the bit just sampled, and go to HOLD.
  - Otherwise `idx` ← `idx`+1, `cnt` ← 0, and return to SETTLE.
- HOLD:
  - `word1` and `word2` are stable.
  - `ack`=1 and `start`=0: go to IDLE.
  - `ack`=1 and `start`=1: back-to-back scan. Apply the IDLE start actions and go directly to SETTLE.
  - `ack`=0: stay in HOLD and ignore `start`.
- `start` is ignored in SETTLE and SAMPLE. `ack` is ignored outside HOLD.
- A disabled group yields a 0 bit for every code, which matches the selector's behaviour when disabled. Its enable stays high for the whole scan.
- `word1`/`word2` change only on entry to HOLD. They keep their value through IDLE and the next scan until the next HOLD entry.

## Timing
- Reset values, one edge after `reset`=1:
  - State IDLE; `idx`, `cnt`, `mask_r`, `sh1`, `sh2` = 0.
  - `sel0`=`sel1`=0; `enb1_n`=`enb2_n`=1.
  - `word1`=`word2`=0; `valid`=0; `busy`=0.
- Reset overrides every other input in the same cycle.
- Reset mid-scan aborts the scan: no `valid` pulse and `word1`/`word2` cleared.
- Each select code is presented for SETTLE+1 cycles: SETTLE in SETTLE plus 1 in SAMPLE.
- The sample is taken at the final edge of that window, so the selector sees at least SETTLE full cycles of stable select before sampling.
- Latency:
  - Start accepted at edge E0.
  - `valid` rises after edge E0 + 4·(SETTLE+1). With SETTLE=2 that is E0+12.
  - `busy` is high from E0+1 through E0+4·(SETTLE+1)-1.
- Select codes advance in order 00, 01, 10, 11, with no glitch cycles between codes.
- In HOLD with `ack`, `valid` falls after that edge.
- Back-to-back: with `ack`+`start` together, `busy` rises on the same edge that `valid` falls.

## Test plan
- Reset: hold `reset` 2 cycles, then check every output against the reset values. Assert `start` together with `reset` and confirm it is not accepted (`busy`=0 after the edge).
- Basic scan, SETTLE=2, `en_mask`=11, selector model with G1C3..0=1010 and G2C3..0=0110, `start` pulse: `word1`=1010, `word2`=0110, `valid` rises 12 cycles after the start edge, and `sel` shows 00,01,10,11 for 3 cycles each.
- Masking, `en_mask`=01, same data: `enb2_n` stays 1 for the whole scan, `word1`=1010, `word2`=0000.
- Handshake: leave `ack` low 20 cycles and pulse `start` during HOLD. `valid` and words stay stable and no new scan begins. Then `ack` alone returns to IDLE with `valid`=0 after 1 cycle.
- Back-to-back: `ack`+`start` in HOLD after changing G1C to 0101. `busy` rises the same edge `valid` falls, and the second `word1`=0101.
- Abort, SETTLE=15: assert `reset` while `idx`=2. Outputs return to reset values, no `valid` pulse, and a fresh scan then completes in 64 cycles.
